// File: rtl/binary_bbox_overlay.sv
// Binary-mask bounding box tracker with perimeter overlay.
// Accumulates the extent of flagged pixels inside a fixed window over one
// frame, commits the box at the next frame boundary, and draws the committed
// (previous-frame) box on the passing video stream with one cycle of latency.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | after reset; pixels ignored until the first frame boundary
// ACCUM  | tracking min/max/count of qualifying pixels in the current frame
// COMMIT | one cycle: publish running box, reload running state
module binary_bbox_overlay #(
  parameter int          WIN_X0     = 31,
  parameter int          WIN_X1     = 449,
  parameter int          WIN_Y0     = 31,
  parameter int          WIN_Y1     = 239,
  parameter int          MIN_PIXELS = 16,
  parameter logic [23:0] BOX_COLOR  = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [23:0] i_data,
  input  logic        i_flag,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic [23:0] o_data,
  output logic [11:0] box_x_min,
  output logic [11:0] box_x_max,
  output logic [11:0] box_y_min,
  output logic [11:0] box_y_max,
  output logic        box_valid
);

  localparam logic [11:0] X0   = WIN_X0[11:0];
  localparam logic [11:0] X1   = WIN_X1[11:0];
  localparam logic [11:0] Y0   = WIN_Y0[11:0];
  localparam logic [11:0] Y1   = WIN_Y1[11:0];
  localparam logic [19:0] MINP = MIN_PIXELS[19:0];

  typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

  state_t      state;
  logic [11:0] run_x_min;
  logic [11:0] run_x_max;
  logic [11:0] run_y_min;
  logic [11:0] run_y_max;
  logic [19:0] run_cnt;

  logic boundary;
  logic qualify;
  logic on_perim;

  // Frame boundary: o_vs already holds i_vs from the previous cycle.
  always_comb begin
    boundary = ~o_vs & i_vs;
    qualify  = i_de & i_flag &
               (i_x >= X0) & (i_x <= X1) &
               (i_y >= Y0) & (i_y <= Y1);
  end

  // Perimeter test against the committed box only.
  always_comb begin
    on_perim = (((i_x == box_x_min) || (i_x == box_x_max)) &&
                (i_y >= box_y_min) && (i_y <= box_y_max)) ||
               (((i_y == box_y_min) || (i_y == box_y_max)) &&
                (i_x >= box_x_min) && (i_x <= box_x_max));
  end

  // Frame sequencing, running extent accumulation and box commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_x_min <= 12'hFFF;
      run_x_max <= 12'h000;
      run_y_min <= 12'hFFF;
      run_y_max <= 12'h000;
      run_cnt   <= 20'd0;
      box_x_min <= 12'h000;
      box_x_max <= 12'h000;
      box_y_min <= 12'h000;
      box_y_max <= 12'h000;
      box_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (boundary) state <= ACCUM;
        end
        ACCUM: begin
          if (qualify) begin
            if (i_x < run_x_min) run_x_min <= i_x;
            if (i_x > run_x_max) run_x_max <= i_x;
            if (i_y < run_y_min) run_y_min <= i_y;
            if (i_y > run_y_max) run_y_max <= i_y;
            if (run_cnt != 20'hFFFFF) run_cnt <= run_cnt + 20'd1;
          end
          if (boundary) state <= COMMIT;
        end
        COMMIT: begin
          box_x_min <= run_x_min;
          box_x_max <= run_x_max;
          box_y_min <= run_y_min;
          box_y_max <= run_y_max;
          box_valid <= (run_cnt >= MINP);
          // A pixel arriving now belongs to the new frame: seed from it.
          if (qualify) begin
            run_x_min <= i_x;
            run_x_max <= i_x;
            run_y_min <= i_y;
            run_y_max <= i_y;
            run_cnt   <= 20'd1;
          end else begin
            run_x_min <= 12'hFFF;
            run_x_max <= 12'h000;
            run_y_min <= 12'hFFF;
            run_y_max <= 12'h000;
            run_cnt   <= 20'd0;
          end
          state <= ACCUM;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Video pipeline: one-cycle delay of sync/position and overlaid pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hs   <= 1'b0;
      o_vs   <= 1'b0;
      o_de   <= 1'b0;
      o_x    <= 12'h000;
      o_y    <= 12'h000;
      o_data <= 24'h000000;
    end else begin
      o_hs <= i_hs;
      o_vs <= i_vs;
      o_de <= i_de;
      o_x  <= i_x;
      o_y  <= i_y;
      if (!i_de)                      o_data <= 24'h000000;
      else if (box_valid && on_perim) o_data <= BOX_COLOR;
      else                            o_data <= i_data;
    end
  end

endmodule

// File: tb/tb_binary_bbox_overlay.sv
// Directed bench for binary_bbox_overlay: box tracking, thresholds, window
// edges, overlay drawing, commit-cycle pixel handling and mid-frame reset.
module tb_binary_bbox_overlay;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0, i_flag = 1'b0;
  logic [11:0] i_x = '0, i_y = '0;
  logic [23:0] i_data = '0;
  logic        o_hs, o_vs, o_de, box_valid;
  logic [11:0] o_x, o_y, box_x_min, box_x_max, box_y_min, box_y_max;
  logic [23:0] o_data;

  int checks = 0;
  int failures = 0;

  binary_bbox_overlay dut (
    .clk(clk), .rst_n(rst_n),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_x(i_x), .i_y(i_y), .i_data(i_data), .i_flag(i_flag),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
    .o_x(o_x), .o_y(o_y), .o_data(o_data),
    .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max),
    .box_valid(box_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [11:0] x, input logic [11:0] y, input logic de,
                       input logic flag, input logic [23:0] data);
    @(negedge clk);
    i_x = x; i_y = y; i_de = de; i_flag = flag; i_data = data; i_vs = 1'b0; i_hs = 1'b0;
  endtask

  task automatic sample();
    @(posedge clk); #1;
  endtask

  // vs high for one cycle, then low; returns just after the COMMIT edge.
  task automatic boundary();
    @(negedge clk);
    i_vs = 1'b1; i_de = 1'b0; i_flag = 1'b0;
    @(negedge clk);
    i_vs = 1'b0;
    sample();
  endtask

  task automatic chk_box(input string tag, input logic [11:0] x0, input logic [11:0] x1,
                         input logic [11:0] y0, input logic [11:0] y1, input logic v);
    chk({tag, ".x_min"}, box_x_min, x0);
    chk({tag, ".x_max"}, box_x_max, x1);
    chk({tag, ".y_min"}, box_y_min, y0);
    chk({tag, ".y_max"}, box_y_max, y1);
    chk({tag, ".valid"}, box_valid, v);
  endtask

  task automatic pix_chk(input string tag, input logic [11:0] x, input logic [11:0] y,
                         input logic [23:0] data, input logic [23:0] exp);
    drive(x, y, 1'b1, 1'b0, data);
    sample();
    chk({tag, ".data"}, o_data, exp);
    chk({tag, ".x"}, o_x, x);
    chk({tag, ".y"}, o_y, y);
    chk({tag, ".de"}, o_de, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.o_data", o_data, 24'h0);
    chk("rst.o_vs", o_vs, 1'b0);
    chk_box("rst", 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // IDLE ignores pixels; first boundary enters ACCUM, no commit yet
    for (int i = 0; i < 20; i++) drive(12'd200, 12'd100 + 12'(i), 1'b1, 1'b1, 24'h1);
    boundary();
    chk_box("idle", 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);

    // 10x10 square at x=100..109, y=50..59
    for (int y = 50; y < 60; y++)
      for (int x = 100; x < 110; x++)
        drive(12'(x), 12'(y), 1'b1, 1'b1, 24'h0000AA);
    // vs pass-through check on the boundary itself
    @(negedge clk);
    i_vs = 1'b1; i_de = 1'b0; i_flag = 1'b0; i_hs = 1'b1;
    sample();
    chk("sync.o_vs", o_vs, 1'b1);
    chk("sync.o_hs", o_hs, 1'b1);
    @(negedge clk);
    i_vs = 1'b0; i_hs = 1'b0;
    sample();
    chk_box("square", 12'd100, 12'd109, 12'd50, 12'd59, 1'b1);

    // Overlay on the committed square
    pix_chk("ov_left", 12'd100, 12'd55, 24'h123456, 24'hFF0000);
    pix_chk("ov_top", 12'd105, 12'd50, 24'h123456, 24'hFF0000);
    pix_chk("ov_corner", 12'd109, 12'd59, 24'h123456, 24'hFF0000);
    pix_chk("ov_inside", 12'd105, 12'd55, 24'h123456, 24'h123456);
    pix_chk("ov_outside", 12'd99, 12'd55, 24'h654321, 24'h654321);
    drive(12'd100, 12'd55, 1'b0, 1'b0, 24'h777777);
    sample();
    chk("ov_blank.data", o_data, 24'h0);
    chk("ov_blank.de", o_de, 1'b0);

    // 15 flagged pixels: box updated but not valid
    for (int i = 0; i < 15; i++) drive(12'd200, 12'd100 + 12'(i), 1'b1, 1'b1, 24'h2);
    boundary();
    chk_box("cnt15", 12'd200, 12'd200, 12'd100, 12'd114, 1'b0);

    // No overlay while box invalid, then 16 pixels gives valid
    pix_chk("noov", 12'd200, 12'd100, 24'h0000F0, 24'h0000F0);
    for (int i = 0; i < 16; i++) drive(12'd210 + 12'(i), 12'd120, 1'b1, 1'b1, 24'h3);
    boundary();
    chk_box("cnt16", 12'd210, 12'd225, 12'd120, 12'd120, 1'b1);

    // Flags only outside the window
    for (int i = 0; i < 20; i++) drive(12'd20, 12'd100 + 12'(i), 1'b1, 1'b1, 24'h4);
    for (int i = 0; i < 20; i++) drive(12'd150 + 12'(i), 12'd250, 1'b1, 1'b1, 24'h4);
    boundary();
    chk_box("outside", 12'hFFF, 12'h000, 12'hFFF, 12'h000, 1'b0);

    // Window edges inclusive; just-outside pixels rejected
    drive(12'd31, 12'd31, 1'b1, 1'b1, 24'h5);
    drive(12'd449, 12'd239, 1'b1, 1'b1, 24'h5);
    drive(12'd30, 12'd100, 1'b1, 1'b1, 24'h5);
    drive(12'd450, 12'd100, 1'b1, 1'b1, 24'h5);
    drive(12'd200, 12'd30, 1'b1, 1'b1, 24'h5);
    drive(12'd200, 12'd240, 1'b1, 1'b1, 24'h5);
    drive(12'd250, 12'd150, 1'b1, 1'b0, 24'h5);  // in window, unflagged
    drive(12'd260, 12'd150, 1'b0, 1'b1, 24'h5);  // flagged, de low
    for (int i = 0; i < 14; i++) drive(12'd200, 12'd100, 1'b1, 1'b1, 24'h5);
    boundary();
    chk_box("edges", 12'd31, 12'd449, 12'd31, 12'd239, 1'b1);

    // Pixel in the COMMIT cycle goes to the next frame
    for (int i = 0; i < 16; i++) drive(12'd400, 12'd200 + 12'(i), 1'b1, 1'b1, 24'h6);
    @(negedge clk);
    i_vs = 1'b1; i_de = 1'b0; i_flag = 1'b0;
    drive(12'd120, 12'd80, 1'b1, 1'b1, 24'h6);
    sample();
    chk_box("cmtpix.old", 12'd400, 12'd400, 12'd200, 12'd215, 1'b1);
    for (int i = 0; i < 15; i++) drive(12'd130, 12'd80, 1'b1, 1'b1, 24'h6);
    boundary();
    chk_box("cmtpix.new", 12'd120, 12'd130, 12'd80, 12'd80, 1'b1);

    // Mid-frame reset after 50 flagged pixels
    for (int i = 0; i < 50; i++) drive(12'd300 + 12'(i), 12'd150, 1'b1, 1'b1, 24'h00ABCD);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.o_data", o_data, 24'h0);
    chk("mrst.o_x", o_x, 12'h0);
    chk("mrst.o_de", o_de, 1'b0);
    chk_box("mrst", 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) drive(12'd300 + 12'(i), 12'd160, 1'b1, 1'b1, 24'h7);
    boundary();
    chk_box("mrst.b1", 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
    for (int i = 0; i < 16; i++) drive(12'd70 + 12'(i), 12'd70, 1'b1, 1'b1, 24'h8);
    boundary();
    chk_box("mrst.b2", 12'd70, 12'd85, 12'd70, 12'd70, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
